// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row scan, 2-flop column sync, press/release debounce.
// Define GHOST_REJECT_EN to reject samples showing more than one closed column.
module keypad_scanner #(
    parameter int SETTLE_CYCLES   = 4,
    parameter int DEBOUNCE_CYCLES = 20
) (
    input  logic       Clock_scan,
    input  logic       reset,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       key_held,
    output logic       key_press
);

    localparam int MAXC = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] DEB_DONE    = CW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_RELEASE} state_t;

    state_t        state_q, state_d;
    logic [1:0]    row_q, row_d;
    logic [1:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    code_q, code_d;
    logic          held_q, held_d;
    logic          press_q, press_d;
    logic [3:0]    sync1_q, cols_q;

    logic [3:0]    col_low;
    logic          cand_low;
    logic          ghost;
    logic [CW-1:0] cnt_inc;

    function automatic logic [1:0] lowest_col(input logic [3:0] low);
        if (low[0]) return 2'd0;
        if (low[1]) return 2'd1;
        if (low[2]) return 2'd2;
        return 2'd3;
    endfunction

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: return 4'd1;   4'h1: return 4'd2;   4'h2: return 4'd3;   4'h3: return 4'd10;
            4'h4: return 4'd4;   4'h5: return 4'd5;   4'h6: return 4'd6;   4'h7: return 4'd11;
            4'h8: return 4'd7;   4'h9: return 4'd8;   4'hA: return 4'd9;   4'hB: return 4'd12;
            4'hC: return 4'd14;  4'hD: return 4'd0;   4'hE: return 4'd15;  default: return 4'd13;
        endcase
    endfunction

    assign col_low  = ~cols_q;
    assign cand_low = col_low[cand_q];
    assign cnt_inc  = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
`ifdef GHOST_REJECT_EN
    assign ghost = (col_low & (col_low - 4'd1)) != 4'd0;
`else
    assign ghost = 1'b0;
`endif

    always_ff @(posedge Clock_scan or posedge reset) begin
        if (reset) begin
            sync1_q <= 4'hF;
            cols_q  <= 4'hF;
        end else begin
            sync1_q <= col_in;
            cols_q  <= sync1_q;
        end
    end

    always_ff @(posedge Clock_scan or posedge reset) begin
        if (reset) begin
            state_q <= SCAN;
            row_q   <= 2'd0;
            cand_q  <= 2'd0;
            cnt_q   <= '0;
            code_q  <= 4'd0;
            held_q  <= 1'b0;
            press_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            held_q  <= held_d;
            press_q <= press_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        held_d  = held_q;
        press_d = 1'b0;
        case (state_q)
            SCAN: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d = '0;
                    if (col_low != 4'd0 && !ghost) begin
                        cand_d  = lowest_col(col_low);
                        state_d = DEB_PRESS;
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            DEB_PRESS: begin
                if (!cand_low || ghost) begin
                    state_d = SCAN;
                    row_d   = row_q + 2'd1;
                    cnt_d   = '0;
                end else if (cnt_inc == DEB_DONE) begin
                    code_d  = key_map(row_q, cand_q);
                    state_d = HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            HELD: begin
                // key_held rises one cycle after key_code loaded; re-entry from DEB_RELEASE gives no strobe
                held_d  = 1'b1;
                press_d = !held_q;
                if (!cand_low) begin
                    state_d = DEB_RELEASE;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (cand_low) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_inc == DEB_DONE) begin
                    held_d  = 1'b0;
                    state_d = SCAN;
                    row_d   = row_q + 2'd1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
        endcase
    end

    assign row_out   = ~(4'b0001 << row_q);
    assign key_code  = code_q;
    assign key_held  = held_q;
    assign key_press = press_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: expected key codes are queued per stimulus, a monitor checks each key_press.
module tb_keypad_scanner;

    localparam int S = 4;
    localparam int D = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic [3:0] key_code;
    logic       key_held;
    logic       key_press;
    logic [15:0] keys;

    int tests = 0;
    int fails = 0;
    int exp_q[$];
    int last_code = 0;
    bit mon_en = 0;
    logic [3:0] prev_code = 4'd0;
    logic       prev_held = 1'b0;

    int MAP[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    keypad_scanner #(.SETTLE_CYCLES(S), .DEBOUNCE_CYCLES(D)) dut (
        .Clock_scan(clk),
        .reset     (rst),
        .col_in    (col_in),
        .row_out   (row_out),
        .key_code  (key_code),
        .key_held  (key_held),
        .key_press (key_press)
    );

    always #5 clk = ~clk;

    // Physical keypad: a closed key pulls its column low while its row is driven low.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!row_out[r]) col_in = col_in & ~keys[r*4 +: 4];
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_held(input logic v, input int maxc, input string name, output int n);
        n = 0;
        while (key_held !== v && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(key_held), int'(v));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int kidx(input int r, input int c);
        return r * 4 + c;
    endfunction

    // Monitor: pops the scoreboard on every key_press and checks edge/stability rules.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (key_press) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_press", int'(key_code), -1);
                end else begin
                    check("press_code", int'(key_code), exp_q.pop_front());
                    check("code_setup_before_held", int'(prev_code), int'(key_code));
                end
            end
            if (key_press || (key_held && !prev_held))
                check("press_on_held_rise", int'(key_press), int'(key_held && !prev_held));
            if (key_code != prev_code)
                check("code_changed_while_held", int'(prev_held || key_held), 0);
        end
        prev_code <= key_code;
        prev_held <= key_held;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int r, c;
        bit long_press;
        keys = 16'h0;
        rst  = 1'b1;
        idle(3);
        check("reset_row_out", int'(row_out), 4'b1110);
        check("reset_key_code", int'(key_code), 0);
        check("reset_key_held", int'(key_held), 0);
        check("reset_key_press", int'(key_press), 0);
        rst = 1'b0;
        mon_en = 1;

        // Idle scan: row advances every S clocks
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            check("idle_row_out", int'(row_out), int'(~(4'b0001 << ((k / S) % 4)) & 4'hF));
        end
        check("idle_key_held", int'(key_held), 0);

        // "5" held 200 cycles, release latency
        exp_q.push_back(5); last_code = 5;
        keys[kidx(1, 1)] = 1'b1;
        wait_held(1'b1, 60, "key5_held_rise", n);
        idle(200 - n);
        keys = 16'h0;
        wait_held(1'b0, 40, "key5_held_fall", n);
        check_range("key5_release_latency", n, D + 2, D + 3);
        idle(20);
        check("key5_code_kept", int'(key_code), 5);

        // ALARM with bounce on press and release
        exp_q.push_back(12); last_code = 12;
        repeat (3) begin
            keys[kidx(2, 3)] = 1'b1; idle(3);
            keys[kidx(2, 3)] = 1'b0; idle(3);
        end
        keys[kidx(2, 3)] = 1'b1;
        wait_held(1'b1, 80, "alarm_held_rise", n);
        idle(40);
        repeat (3) begin
            keys[kidx(2, 3)] = 1'b0; idle(3);
            keys[kidx(2, 3)] = 1'b1; idle(3);
        end
        check("alarm_held_through_bounce", int'(key_held), 1);
        keys = 16'h0;
        wait_held(1'b0, 40, "alarm_held_fall", n);
        idle(20);

        // "0" for 5 cycles only: aborted
        keys[kidx(3, 1)] = 1'b1; idle(5);
        keys = 16'h0; idle(30);
        check("short_press_held", int'(key_held), 0);
        check("short_press_code_kept", int'(key_code), last_code);

        // "1" held, other keys added later are ignored
        exp_q.push_back(1); last_code = 1;
        keys[kidx(0, 0)] = 1'b1;
        wait_held(1'b1, 60, "key1_held_rise", n);
        keys[kidx(0, 2)] = 1'b1;
        keys[kidx(1, 0)] = 1'b1;
        idle(50);
        check("key1_code_with_extra_keys", int'(key_code), 1);
        keys = 16'h0;
        wait_held(1'b0, 40, "key1_held_fall", n);
        idle(20);
        exp_q.push_back(1);
        keys[kidx(0, 0)] = 1'b1;
        wait_held(1'b1, 60, "key1_again_rise", n);
        idle(10);
        keys = 16'h0;
        wait_held(1'b0, 40, "key1_again_fall", n);
        idle(20);

        // r0/c0 and r0/c3 together
        keys[kidx(0, 0)] = 1'b1;
        keys[kidx(0, 3)] = 1'b1;
`ifdef GHOST_REJECT_EN
        idle(80);
        check("ghost_rejected_held", int'(key_held), 0);
        keys = 16'h0;
        idle(20);
`else
        exp_q.push_back(1); last_code = 1;
        wait_held(1'b1, 60, "ghost_lowest_col_rise", n);
        check("ghost_lowest_col_code", int'(key_code), 1);
        idle(10);
        keys = 16'h0;
        wait_held(1'b0, 40, "ghost_lowest_col_fall", n);
        idle(20);
`endif

        // Randomized single-key presses, long (accepted) or short (aborted)
        for (int i = 0; i < 12; i++) begin
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            long_press = ($urandom_range(0, 2) != 0);
            keys[kidx(r, c)] = 1'b1;
            if (long_press) begin
                exp_q.push_back(MAP[kidx(r, c)]);
                last_code = MAP[kidx(r, c)];
                wait_held(1'b1, 60, "rand_held_rise", n);
                idle($urandom_range(1, 30));
                keys = 16'h0;
                wait_held(1'b0, 40, "rand_held_fall", n);
            end else begin
                idle($urandom_range(1, 5));
                keys = 16'h0;
            end
            idle(20);
            check("rand_code", int'(key_code), last_code);
        end

        // Asynchronous reset while a key is held
        exp_q.push_back(9);
        keys[kidx(2, 2)] = 1'b1;
        wait_held(1'b1, 60, "key9_held_rise", n);
        idle(5);
        rst = 1'b1;
        #1;
        check("async_reset_key_held", int'(key_held), 0);
        check("async_reset_row_out", int'(row_out), 4'b1110);
        check("async_reset_key_code", int'(key_code), 0);
        check("async_reset_key_press", int'(key_press), 0);
        keys = 16'h0;
        idle(3);
        rst = 1'b0;
        idle(20);
        check("after_reset_key_held", int'(key_held), 0);

        check("missing_press", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
